data_bus_arbiter: RTL

DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

---
 rtl/data_bus_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: two-requester round-robin arbiter onto a single memory-mapped slave port.
// Ports: clk/rst (sync active-high); m0_*/m1_* requester req/we/addr/wd in, rd/done/stall out;
//        s_we/s_re/s_addr/s_wd slave strobes and address/data out, s_rd/s_ready slave response in;
//        grant one-hot bus owner; timeout_err sticky flag for accesses forced complete by the watchdog.
module data_bus_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wd,
    output logic [DATA_WIDTH-1:0] m0_rd,
    output logic                  m0_done,
    output logic                  m0_stall,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wd,
    output logic [DATA_WIDTH-1:0] m1_rd,
    output logic                  m1_done,
    output logic                  m1_stall,
    output logic                  s_we,
    output logic                  s_re,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wd,
    input  logic [DATA_WIDTH-1:0] s_rd,
    input  logic                  s_ready,
    output logic [1:0]            grant,
    output logic                  timeout_err
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state, state_nx;
    logic                  last;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wd;
    logic [CW-1:0]         cnt;
    logic                  pick1;
    logic                  to_hit;
    logic                  finish;

    // last=1 means m1 was served most recently, so m0 wins a tie
    assign pick1  = m1_req & (~m0_req | ~last);
    assign to_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    // a ready slave on the final watchdog cycle still completes normally
    assign finish = s_ready | to_hit;

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? ((m0_req | m1_req) ? BUSY : IDLE) :
                   state == BUSY ? (finish ? RESP : BUSY) : IDLE;
        s_we     = (state == BUSY) && lat_we;
        s_re     = (state == BUSY) && !lat_we;
        m0_done  = (state == RESP) && grant[0];
        m1_done  = (state == RESP) && grant[1];
        m0_stall = m0_req & ~m0_done;
        m1_stall = m1_req & ~m1_done;
        s_addr   = lat_addr;
        s_wd     = lat_wd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant       <= 2'b00;
            last        <= 1'b1;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wd      <= '0;
            cnt         <= '0;
            m0_rd       <= '0;
            m1_rd       <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == IDLE && (m0_req | m1_req)) begin
                grant    <= pick1 ? 2'b10 : 2'b01;
                lat_we   <= pick1 ? m1_we : m0_we;
                lat_addr <= pick1 ? m1_addr : m0_addr;
                lat_wd   <= pick1 ? m1_wd : m0_wd;
                cnt      <= '0;
            end
            if (state == BUSY) begin
                cnt <= cnt + 1'b1;
                if (finish) begin
                    if (grant[0]) m0_rd <= s_ready ? s_rd : '0;
                    if (grant[1]) m1_rd <= s_ready ? s_rd : '0;
                    if (!s_ready) timeout_err <= 1'b1;
                end
            end
            if (state == RESP) begin
                grant <= 2'b00;
                last  <= grant[1];
            end
        end
    end
endmodule
